// File: rtl/wave_gen_if.sv
// Control/data bundle between the function-generator sequencer and wave_gen.
// The sequencer drives the master side; wave_gen implements the slave side.
interface wave_gen_if #(
  parameter int DATA_W = 10,
  parameter int ACC_W  = 16
);
  logic              enable;
  logic              load;
  logic [1:0]        mode_in;
  logic [ACC_W-1:0]  freq_in;
  logic [DATA_W-1:0] duty_in;
  logic [DATA_W-1:0] dac_data;
  logic              period_tick;
  logic              pending;

  modport master (
    output enable, load, mode_in, freq_in, duty_in,
    input  dac_data, period_tick, pending
  );

  modport slave (
    input  enable, load, mode_in, freq_in, duty_in,
    output dac_data, period_tick, pending
  );
endinterface

// File: rtl/wave_gen.sv
// Phase-accumulator waveform generator (saw, triangle, square, falling ramp).
// Mode/freq/duty changes made while running are held in a shadow set until the next wrap.
module wave_gen #(
  parameter int DATA_W = 10,
  parameter int ACC_W  = 16   // must be at least DATA_W+1
) (
  input  logic      dac_clk,
  input  logic      dac_rst_n,
  wave_gen_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [1:0] MODE_SAW  = 2'd0;
  localparam logic [1:0] MODE_TRI  = 2'd1;
  localparam logic [1:0] MODE_SQR  = 2'd2;
  localparam logic [1:0] MODE_FALL = 2'd3;

  localparam logic [ACC_W-1:0]  FREQ_RST = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DUTY_RST = {1'b1, {(DATA_W-1){1'b0}}};

  logic [0:0]        state_q,   state_d;
  logic [ACC_W-1:0]  acc_q,     acc_d;
  logic [1:0]        mode_q,    mode_d;
  logic [ACC_W-1:0]  freq_q,    freq_d;
  logic [DATA_W-1:0] duty_q,    duty_d;
  logic [1:0]        sh_mode_q, sh_mode_d;
  logic [ACC_W-1:0]  sh_freq_q, sh_freq_d;
  logic [DATA_W-1:0] sh_duty_q, sh_duty_d;
  logic              pending_q, pending_d;
  logic [DATA_W-1:0] dac_q,     dac_d;
  logic              tick_q,    tick_d;

  logic [ACC_W:0]    sum;
  logic              wrap;
  logic [DATA_W-1:0] saw_s;
  logic [DATA_W-1:0] tri_t;
  logic [DATA_W-1:0] wave;

  assign sum   = {1'b0, acc_q} + {1'b0, freq_q};
  assign wrap  = sum[ACC_W];
  assign saw_s = acc_q[ACC_W-1 -: DATA_W];
  // One bit lower than saw_s so the triangle climbs and falls within a single accumulator period
  assign tri_t = acc_q[ACC_W-2 -: DATA_W];

  always_comb begin
    wave = saw_s;
    case (mode_q)
      MODE_SAW:  wave = saw_s;
      MODE_TRI:  wave = acc_q[ACC_W-1] ? ~tri_t : tri_t;
      MODE_SQR:  wave = (saw_s < duty_q) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
      MODE_FALL: wave = ~saw_s;
      default:   wave = saw_s;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mode_d    = mode_q;
    freq_d    = freq_q;
    duty_d    = duty_q;
    sh_mode_d = sh_mode_q;
    sh_freq_d = sh_freq_q;
    sh_duty_d = sh_duty_q;
    pending_d = pending_q;
    dac_d     = dac_q;
    tick_d    = tick_q;

    case (state_q)
      ST_IDLE: begin
        acc_d  = '0;
        dac_d  = '0;
        tick_d = 1'b0;
        // Nothing is being played, so a load takes effect at once
        if (bus.load) begin
          mode_d    = bus.mode_in;
          freq_d    = bus.freq_in;
          duty_d    = bus.duty_in;
          sh_mode_d = bus.mode_in;
          sh_freq_d = bus.freq_in;
          sh_duty_d = bus.duty_in;
        end
        pending_d = 1'b0;
        if (bus.enable) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (!bus.enable) begin
          state_d   = ST_IDLE;
          acc_d     = '0;
          dac_d     = '0;
          tick_d    = 1'b0;
          pending_d = 1'b0;
          if (bus.load) begin
            mode_d    = bus.mode_in;
            freq_d    = bus.freq_in;
            duty_d    = bus.duty_in;
            sh_mode_d = bus.mode_in;
            sh_freq_d = bus.freq_in;
            sh_duty_d = bus.duty_in;
          end else if (pending_q) begin
            mode_d = sh_mode_q;
            freq_d = sh_freq_q;
            duty_d = sh_duty_q;
          end
        end else begin
          acc_d  = sum[ACC_W-1:0];
          dac_d  = wave;
          tick_d = wrap;
          // A load landing on the wrap edge needs no deferral: this edge is the boundary
          if (bus.load && wrap) begin
            mode_d    = bus.mode_in;
            freq_d    = bus.freq_in;
            duty_d    = bus.duty_in;
            sh_mode_d = bus.mode_in;
            sh_freq_d = bus.freq_in;
            sh_duty_d = bus.duty_in;
            pending_d = 1'b0;
          end else if (bus.load) begin
            sh_mode_d = bus.mode_in;
            sh_freq_d = bus.freq_in;
            sh_duty_d = bus.duty_in;
            pending_d = 1'b1;
          end else if (wrap && pending_q) begin
            mode_d    = sh_mode_q;
            freq_d    = sh_freq_q;
            duty_d    = sh_duty_q;
            pending_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge dac_clk or negedge dac_rst_n) begin
    if (!dac_rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      mode_q    <= MODE_SAW;
      freq_q    <= FREQ_RST;
      duty_q    <= DUTY_RST;
      sh_mode_q <= MODE_SAW;
      sh_freq_q <= FREQ_RST;
      sh_duty_q <= DUTY_RST;
      pending_q <= 1'b0;
      dac_q     <= '0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mode_q    <= mode_d;
      freq_q    <= freq_d;
      duty_q    <= duty_d;
      sh_mode_q <= sh_mode_d;
      sh_freq_q <= sh_freq_d;
      sh_duty_q <= sh_duty_d;
      pending_q <= pending_d;
      dac_q     <= dac_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.dac_data    = dac_q;
  assign bus.period_tick = tick_q;
  assign bus.pending     = pending_q;

endmodule

// File: tb/tb_wave_gen.sv
// Randomised and directed checks of wave_gen against an arithmetic reference model.
// The model tracks phase as an integer and derives samples with plain division.
module tb_wave_gen;

  localparam int DATA_W = 10;
  localparam int ACC_W  = 16;
  localparam int NS     = 1 << DATA_W;
  localparam int DMAX   = NS - 1;
  localparam int NPH    = 1 << ACC_W;
  localparam int HALF   = NPH / 2;
  localparam int SHIFT  = ACC_W - DATA_W;

  logic dac_clk = 1'b0;
  logic dac_rst_n;

  wave_gen_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  wave_gen #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .dac_clk   (dac_clk),
    .dac_rst_n (dac_rst_n),
    .bus       (bus)
  );

  always #5 dac_clk = ~dac_clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit                m_run;
  int                m_phase;
  int                m_mode, m_freq, m_duty;
  int                s_mode, s_freq, s_duty;
  bit                exp_pend;
  bit                exp_tick;
  logic [DATA_W-1:0] exp_dac;

  function automatic int ref_wave(int phase, int mode, int duty);
    int saw;
    saw = phase / (1 << SHIFT);
    case (mode)
      0:       return saw;
      1:       return (phase < HALF) ? phase / (1 << (SHIFT - 1))
                                     : DMAX - (phase - HALF) / (1 << (SHIFT - 1));
      2:       return (saw < duty) ? DMAX : 0;
      default: return DMAX - saw;
    endcase
  endfunction

  function automatic void model_reset();
    m_run = 0; m_phase = 0;
    m_mode = 0; m_freq = 1; m_duty = NS / 2;
    s_mode = 0; s_freq = 1; s_duty = NS / 2;
    exp_pend = 0; exp_tick = 0; exp_dac = '0;
  endfunction

  function automatic void model_edge();
    int ld_mode, ld_freq, ld_duty, total;
    bit ld, en, wrapped;
    ld = bus.load; en = bus.enable;
    ld_mode = int'(bus.mode_in); ld_freq = int'(bus.freq_in); ld_duty = int'(bus.duty_in);
    if (!m_run) begin
      exp_dac = '0; exp_tick = 0; m_phase = 0;
      if (ld) begin
        m_mode = ld_mode; m_freq = ld_freq; m_duty = ld_duty;
        s_mode = ld_mode; s_freq = ld_freq; s_duty = ld_duty;
      end
      m_run = en;
    end else if (!en) begin
      m_run = 0; m_phase = 0; exp_dac = '0; exp_tick = 0;
      if (ld) begin
        m_mode = ld_mode; m_freq = ld_freq; m_duty = ld_duty;
      end else if (exp_pend) begin
        m_mode = s_mode; m_freq = s_freq; m_duty = s_duty;
      end
      exp_pend = 0;
    end else begin
      total    = m_phase + m_freq;
      wrapped  = (total >= NPH);
      exp_dac  = DATA_W'(ref_wave(m_phase, m_mode, m_duty));
      exp_tick = wrapped;
      m_phase  = total % NPH;
      if (ld && wrapped) begin
        m_mode = ld_mode; m_freq = ld_freq; m_duty = ld_duty;
        exp_pend = 0;
      end else if (ld) begin
        s_mode = ld_mode; s_freq = ld_freq; s_duty = ld_duty;
        exp_pend = 1;
      end else if (wrapped && exp_pend) begin
        m_mode = s_mode; m_freq = s_freq; m_duty = s_duty;
        exp_pend = 0;
      end
    end
  endfunction

  task automatic step();
    @(posedge dac_clk);
    model_edge();
    @(negedge dac_clk);
  endtask

  task automatic do_load(input int mode, input int freq, input int duty);
    bus.load    = 1'b1;
    bus.mode_in = 2'(mode);
    bus.freq_in = ACC_W'(freq);
    bus.duty_in = DATA_W'(duty);
    step();
    bus.load = 1'b0;
  endtask

  task automatic go_idle();
    bus.load   = 1'b0;
    bus.enable = 1'b0;
    step();
  endtask

  task automatic test_reset();
    bus.enable = 1'b0; bus.load = 1'b0;
    bus.mode_in = '0; bus.freq_in = '0; bus.duty_in = '0;
    dac_rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge dac_clk);
    n_cmp++;
    if (bus.dac_data !== '0) begin
      n_err++; $display("FAIL reset_dac: got %0d want 0", bus.dac_data);
    end
    n_cmp++;
    if (bus.period_tick !== 1'b0) begin
      n_err++; $display("FAIL reset_tick: got %b want 0", bus.period_tick);
    end
    n_cmp++;
    if (bus.pending !== 1'b0) begin
      n_err++; $display("FAIL reset_pending: got %b want 0", bus.pending);
    end
    dac_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (bus.dac_data !== exp_dac || bus.period_tick !== exp_tick || bus.pending !== exp_pend) begin
        n_err++;
        $display("FAIL reset_idle i=%0d: got dac=%0d tick=%b pend=%b want dac=%0d tick=%b pend=%b",
                 i, bus.dac_data, bus.period_tick, bus.pending, exp_dac, exp_tick, exp_pend);
      end
    end
    $display("test_reset: reset values and idle hold checked");
  endtask

  task automatic test_sawtooth();
    go_idle();
    do_load(0, 64, NS / 2);
    n_cmp++;
    if (bus.pending !== 1'b0) begin
      n_err++; $display("FAIL saw_idle_load_pending: got %b want 0", bus.pending);
    end
    bus.enable = 1'b1;
    step();
    for (int i = 0; i < NS + 8; i++) begin
      step();
      n_cmp++;
      if (bus.dac_data !== DATA_W'(i % NS) || bus.period_tick !== ((i % NS) == NS - 1)) begin
        n_err++;
        $display("FAIL saw_seq i=%0d: got dac=%0d tick=%b want dac=%0d tick=%b",
                 i, bus.dac_data, bus.period_tick, i % NS, (i % NS) == NS - 1);
      end
      n_cmp++;
      if (bus.dac_data !== exp_dac || bus.period_tick !== exp_tick || bus.pending !== exp_pend) begin
        n_err++;
        $display("FAIL saw_model i=%0d: got dac=%0d tick=%b pend=%b want dac=%0d tick=%b pend=%b",
                 i, bus.dac_data, bus.period_tick, bus.pending, exp_dac, exp_tick, exp_pend);
      end
    end
    $display("test_sawtooth: %0d samples checked", NS + 8);
  endtask

  task automatic test_triangle();
    int want;
    go_idle();
    do_load(1, 32, NS / 2);
    bus.enable = 1'b1;
    step();
    for (int i = 0; i < 2 * NS + 8; i++) begin
      step();
      want = ((i % (2 * NS)) < NS) ? (i % (2 * NS)) : (2 * NS - 1 - (i % (2 * NS)));
      n_cmp++;
      if (bus.dac_data !== DATA_W'(want) || bus.period_tick !== ((i % (2 * NS)) == 2 * NS - 1)) begin
        n_err++;
        $display("FAIL tri_seq i=%0d: got dac=%0d tick=%b want dac=%0d tick=%b",
                 i, bus.dac_data, bus.period_tick, want, (i % (2 * NS)) == 2 * NS - 1);
      end
    end
    $display("test_triangle: %0d samples checked", 2 * NS + 8);
  endtask

  task automatic test_square();
    int want;
    go_idle();
    do_load(2, 64, 256);
    bus.enable = 1'b1;
    step();
    for (int i = 0; i < 2 * NS + 4; i++) begin
      step();
      want = ((i % NS) < 256) ? DMAX : 0;
      n_cmp++;
      if (bus.dac_data !== DATA_W'(want)) begin
        n_err++; $display("FAIL sqr_duty256 i=%0d: got %0d want %0d", i, bus.dac_data, want);
      end
    end
    go_idle();
    do_load(2, 64, 0);
    bus.enable = 1'b1;
    step();
    for (int i = 0; i < NS + 4; i++) begin
      step();
      n_cmp++;
      if (bus.dac_data !== '0 || bus.period_tick !== ((i % NS) == NS - 1)) begin
        n_err++;
        $display("FAIL sqr_duty0 i=%0d: got dac=%0d tick=%b want dac=0 tick=%b",
                 i, bus.dac_data, bus.period_tick, (i % NS) == NS - 1);
      end
    end
    $display("test_square: duty 256 and duty 0 checked");
  endtask

  task automatic test_deferred();
    int  want;
    bit  want_pend;
    bit  found;
    go_idle();
    do_load(0, 64, NS / 2);
    bus.enable = 1'b1;
    step();
    for (int i = 0; i < NS + 80; i++) begin
      if (i == 101) begin
        bus.load = 1'b1; bus.mode_in = 2'd0; bus.freq_in = ACC_W'(128); bus.duty_in = '0;
      end else begin
        bus.load = 1'b0;
      end
      step();
      want      = (i <= NS - 1) ? i : 2 * (i - NS);
      want_pend = (i >= 101 && i <= NS - 2);
      n_cmp++;
      if (bus.dac_data !== DATA_W'(want) || bus.pending !== want_pend) begin
        n_err++;
        $display("FAIL defer_stride i=%0d: got dac=%0d pend=%b want dac=%0d pend=%b",
                 i, bus.dac_data, bus.pending, want, want_pend);
      end
    end
    bus.load = 1'b0;
    found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      if (m_run && (m_phase + m_freq >= NPH)) begin
        found = 1;
      end else begin
        step();
      end
    end
    n_cmp++;
    if (!found) begin
      n_err++; $display("FAIL defer_wrap_wait: got no wrap within 2000 cycles want a wrap");
    end else begin
      do_load(3, 256, 0);
      n_cmp++;
      if (bus.period_tick !== 1'b1 || bus.pending !== 1'b0) begin
        n_err++;
        $display("FAIL defer_load_at_wrap: got tick=%b pend=%b want tick=1 pend=0",
                 bus.period_tick, bus.pending);
      end
      step();
      n_cmp++;
      if (bus.dac_data !== DATA_W'(DMAX) || bus.pending !== 1'b0) begin
        n_err++;
        $display("FAIL defer_new_mode: got dac=%0d pend=%b want dac=%0d pend=0",
                 bus.dac_data, bus.pending, DMAX);
      end
      for (int i = 0; i < 300; i++) begin
        step();
        n_cmp++;
        if (bus.dac_data !== exp_dac || bus.period_tick !== exp_tick || bus.pending !== exp_pend) begin
          n_err++;
          $display("FAIL defer_model i=%0d: got dac=%0d tick=%b pend=%b want dac=%0d tick=%b pend=%b",
                   i, bus.dac_data, bus.period_tick, bus.pending, exp_dac, exp_tick, exp_pend);
        end
      end
    end
    $display("test_deferred: deferred load and load-at-wrap checked");
  endtask

  task automatic test_idle();
    go_idle();
    do_load(1, 100, 0);
    bus.enable = 1'b1;
    step();
    for (int i = 0; i < 520; i++) begin
      if (i == 500) begin
        bus.load = 1'b1; bus.mode_in = 2'd2; bus.freq_in = ACC_W'(300); bus.duty_in = DATA_W'(700);
      end else begin
        bus.load = 1'b0;
      end
      step();
      n_cmp++;
      if (bus.dac_data !== exp_dac || bus.period_tick !== exp_tick || bus.pending !== exp_pend) begin
        n_err++;
        $display("FAIL idle_run_model i=%0d: got dac=%0d tick=%b pend=%b want dac=%0d tick=%b pend=%b",
                 i, bus.dac_data, bus.period_tick, bus.pending, exp_dac, exp_tick, exp_pend);
      end
    end
    go_idle();
    n_cmp++;
    if (bus.dac_data !== '0 || bus.period_tick !== 1'b0 || bus.pending !== 1'b0) begin
      n_err++;
      $display("FAIL idle_drop: got dac=%0d tick=%b pend=%b want dac=0 tick=0 pend=0",
               bus.dac_data, bus.period_tick, bus.pending);
    end
    do_load(3, 64, 0);
    n_cmp++;
    if (bus.pending !== 1'b0 || bus.dac_data !== '0) begin
      n_err++;
      $display("FAIL idle_load: got pend=%b dac=%0d want pend=0 dac=0", bus.pending, bus.dac_data);
    end
    bus.enable = 1'b1;
    step();
    step();
    n_cmp++;
    if (bus.dac_data !== DATA_W'(DMAX)) begin
      n_err++; $display("FAIL idle_first_sample: got %0d want %0d", bus.dac_data, DMAX);
    end
    $display("test_idle: drop, idle load and restart checked");
  endtask

  task automatic test_random();
    int idle_left;
    int f;
    idle_left = 0;
    go_idle();
    do_load(0, 512, NS / 2);
    bus.enable = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      bus.load = 1'b0;
      if (idle_left > 0) begin
        idle_left--;
        bus.enable = 1'b0;
      end else if (m_run && $urandom_range(0, 299) == 0) begin
        idle_left  = $urandom_range(0, 3);
        bus.enable = 1'b0;
      end else begin
        bus.enable = 1'b1;
      end
      if (!(m_run && !bus.enable) && $urandom_range(0, 39) == 0) begin
        f = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(1, 4096);
        bus.load    = 1'b1;
        bus.mode_in = 2'($urandom_range(0, 3));
        bus.freq_in = ACC_W'(f);
        bus.duty_in = DATA_W'($urandom_range(0, DMAX));
      end
      step();
      n_cmp++;
      if (bus.dac_data !== exp_dac || bus.period_tick !== exp_tick || bus.pending !== exp_pend) begin
        n_err++;
        $display("FAIL rand_model i=%0d: got dac=%0d tick=%b pend=%b want dac=%0d tick=%b pend=%b",
                 i, bus.dac_data, bus.period_tick, bus.pending, exp_dac, exp_tick, exp_pend);
      end
    end
    bus.load = 1'b0;
    $display("test_random: 6000 randomised cycles checked");
  endtask

  task automatic test_async_reset();
    go_idle();
    do_load(0, 64, NS / 2);
    bus.enable = 1'b1;
    step();
    repeat (300) step();
    do_load(2, 200, 100);
    n_cmp++;
    if (bus.pending !== 1'b1 || bus.dac_data === '0) begin
      n_err++;
      $display("FAIL areset_setup: got pend=%b dac=%0d want pend=1 dac nonzero", bus.pending, bus.dac_data);
    end
    #2 dac_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.dac_data !== '0 || bus.period_tick !== 1'b0 || bus.pending !== 1'b0) begin
      n_err++;
      $display("FAIL areset_immediate: got dac=%0d tick=%b pend=%b want dac=0 tick=0 pend=0",
               bus.dac_data, bus.period_tick, bus.pending);
    end
    model_reset();
    @(negedge dac_clk);
    dac_rst_n = 1'b1;
    step();
    for (int i = 0; i < 200; i++) begin
      step();
      n_cmp++;
      if (bus.dac_data !== DATA_W'(i / 64) || bus.pending !== 1'b0) begin
        n_err++;
        $display("FAIL areset_default_saw i=%0d: got dac=%0d pend=%b want dac=%0d pend=0",
                 i, bus.dac_data, bus.pending, i / 64);
      end
    end
    $display("test_async_reset: mid-run reset and default sawtooth checked");
  endtask

  initial begin
    test_reset();
    test_sawtooth();
    test_triangle();
    test_square();
    test_deferred();
    test_idle();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
